// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: shares the single physical-memory line port between the
// I-cache and D-cache. A requester seen pending in IDLE is granted on the next
// cycle. Its address, data and strobes are steered to memory until pmem_resp.
// The response and read data are returned only to the granted side.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   icache_read/addr              I-side line-fill request
//   icache_rdata/resp             I-side fill data / completion
//   dcache_read/write/addr/wdata  D-side fill or write-back request
//   dcache_rdata/resp             D-side fill data / completion
//   pmem_read/write/addr/wdata    memory request (steered from granted side)
//   pmem_rdata/resp               memory read line / completion
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both sides
// are pending. Otherwise D always wins over I.
module cache_line_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state, state_nxt;
  grant_t last_grant, last_grant_nxt;
  logic   i_pend, d_pend, pick_d;

  assign i_pend = icache_read;
  assign d_pend = dcache_read | dcache_write;

  // Grant selection used only when leaving IDLE
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_pend && (!i_pend || (last_grant == GRANT_I));
`else
  assign pick_d = d_pend;
`endif

  // State and last-grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next state and steering. Outputs are gated while rst is high so that
  // the reset values appear during reset as well as after it.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_addr      = '0;
    pmem_wdata     = '0;
    icache_resp    = 1'b0;
    icache_rdata   = '0;
    dcache_resp    = 1'b0;
    dcache_rdata   = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          // pmem_resp is ignored here; nothing is outstanding.
          if (pick_d) begin
            state_nxt      = SERVE_D;
            last_grant_nxt = GRANT_D;
          end else if (i_pend) begin
            state_nxt      = SERVE_I;
            last_grant_nxt = GRANT_I;
          end
        end
        SERVE_I: begin
          pmem_read = 1'b1;
          pmem_addr = icache_addr;
          if (pmem_resp) begin
            icache_resp  = 1'b1;
            icache_rdata = pmem_rdata;
            state_nxt    = IDLE;
          end
        end
        SERVE_D: begin
          // An illegal read+write is forwarded as a write only.
          pmem_read  = dcache_read & ~dcache_write;
          pmem_write = dcache_write;
          pmem_addr  = dcache_addr;
          pmem_wdata = dcache_wdata;
          if (pmem_resp) begin
            dcache_resp  = 1'b1;
            dcache_rdata = pmem_rdata;
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A D-side request must never carry both read and write strobes
  a_no_dual_strobe : assert property (@(posedge clk) disable iff (rst)
    !(dcache_read && dcache_write));

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scoreboarded bench for cache_line_arbiter. Expected memory transactions are
// queued in grant order as requests are driven. Each one is popped when the
// arbiter raises a pmem strobe, and it is checked through to the forwarded
// response. Inputs are driven on the falling edge. Outputs are sampled 1 time
// unit later.
module tb_cache_line_arbiter;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic              side;   // 0: I-cache, 1: D-cache
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              icache_read = 1'b0;
  logic [ADDR_W-1:0] icache_addr = '0;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read = 1'b0;
  logic              dcache_write = 1'b0;
  logic [ADDR_W-1:0] dcache_addr = '0;
  logic [LINE_W-1:0] dcache_wdata = '0;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t exp_q[$];

  cache_line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic side, input logic wr,
                              input logic [ADDR_W-1:0] addr,
                              input logic [LINE_W-1:0] wdata,
                              input logic [LINE_W-1:0] rdata);
    txn_t t;
    t.side = side; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Serve the next expected transaction as the memory: wait for the strobe,
  // check the steered request, respond after `delay` cycles, and check the
  // forwarded response. It returns in the IDLE slot after the response.
  task automatic do_txn(input int delay, input bit drop, input int exp_lat);
    txn_t t;
    int   n;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_underflow", LINE_W'(1), LINE_W'(0));
      return;
    end
    t = exp_q.pop_front();
    n = 0;
    while (!(pmem_read || pmem_write) && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("grant_latency", LINE_W'(n), LINE_W'(exp_lat));
    check_eq("pmem_addr", LINE_W'(pmem_addr), LINE_W'(t.addr));
    check_eq("pmem_read", LINE_W'(pmem_read), LINE_W'(!t.wr));
    check_eq("pmem_write", LINE_W'(pmem_write), LINE_W'(t.wr));
    if (t.wr) check_eq("pmem_wdata", pmem_wdata, t.wdata);
    repeat (delay) begin
      @(negedge clk); #1;
      check_eq("resp_while_wait", LINE_W'({icache_resp, dcache_resp}), LINE_W'(0));
    end
    @(negedge clk);
    pmem_rdata = t.rdata;
    pmem_resp  = 1'b1;
    #1;
    check_eq("resp_side", LINE_W'({icache_resp, dcache_resp}),
             t.side ? LINE_W'(2'b01) : LINE_W'(2'b10));
    check_eq("resp_rdata", t.side ? dcache_rdata : icache_rdata, t.rdata);
    check_eq("other_rdata", t.side ? icache_rdata : dcache_rdata, '0);
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (drop) begin
      if (t.side) begin dcache_read = 1'b0; dcache_write = 1'b0; end
      else icache_read = 1'b0;
    end
    #1;
    check_eq("idle_no_strobe", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
    check_eq("idle_no_resp", LINE_W'({icache_resp, dcache_resp}), LINE_W'(0));
  endtask

  localparam logic [LINE_W-1:0] DAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] DAT_12 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] DAT_C3 = {32{8'hC3}};
  localparam logic [LINE_W-1:0] DAT_5A = {32{8'h5A}};

  initial begin
    // Reset held for two edges with both sides requesting
    icache_read = 1'b1; icache_addr = 32'h40;
    dcache_read = 1'b1; dcache_addr = 32'h2000; dcache_wdata = DAT_12;
    repeat (2) begin
      @(negedge clk); #1;
      check_eq("rst_pmem_strobes", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
      check_eq("rst_pmem_addr", LINE_W'(pmem_addr), LINE_W'(0));
      check_eq("rst_pmem_wdata", pmem_wdata, '0);
      check_eq("rst_resp", LINE_W'({icache_resp, dcache_resp}), LINE_W'(0));
      check_eq("rst_rdata", icache_rdata | dcache_rdata, '0);
    end
    rst = 1'b0;
    // After reset last_grant is I, so both builds pick D first
    exp_q.push_back(mk(1'b1, 1'b0, 32'h2000, DAT_12, DAT_C3));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h40, '0, DAT_5A));
    do_txn(2, 1'b1, 1);
    do_txn(1, 1'b1, 1);

    // I-only line fill
    icache_read = 1'b1; icache_addr = 32'h60;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h60, '0, DAT_A5));
    do_txn(5, 1'b1, 1);

    // D write-back
    dcache_write = 1'b1; dcache_addr = 32'h1000; dcache_wdata = DAT_12;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h1000, DAT_12, DAT_5A));
    do_txn(3, 1'b1, 1);

    // Simultaneous reads with last_grant = D
    icache_read = 1'b1; icache_addr = 32'h40;
    dcache_read = 1'b1; dcache_addr = 32'h2000;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1'b0, 1'b0, 32'h40, '0, DAT_A5));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h2000, DAT_12, DAT_C3));
`else
    exp_q.push_back(mk(1'b1, 1'b0, 32'h2000, DAT_12, DAT_C3));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h40, '0, DAT_A5));
`endif
    do_txn(2, 1'b1, 1);
    do_txn(2, 1'b1, 1);

    // Back-to-back: D alone is granted, I arrives mid-serve, and D re-requests
    // right after its resp
    @(negedge clk);
    dcache_read = 1'b1; dcache_addr = 32'h4000;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h4000, DAT_12, DAT_A5));
    @(negedge clk); #1;
    icache_read = 1'b1; icache_addr = 32'h80;
    do_txn(1, 1'b0, 0);
    dcache_addr = 32'h5000;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1'b0, 1'b0, 32'h80, '0, DAT_5A));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h5000, DAT_12, DAT_C3));
`else
    exp_q.push_back(mk(1'b1, 1'b0, 32'h5000, DAT_12, DAT_C3));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h80, '0, DAT_5A));
`endif
    do_txn(1, 1'b1, 1);
    do_txn(1, 1'b1, 1);

    // Reset two cycles into a D read; a late pmem_resp must not leak out
    @(negedge clk);
    dcache_read = 1'b1; dcache_addr = 32'h3000;
    @(negedge clk); #1;
    check_eq("abort_granted", LINE_W'(pmem_read), LINE_W'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dcache_read = 1'b0;
    @(negedge clk); #1;
    check_eq("abort_idle_strobes", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
    check_eq("abort_idle_addr", LINE_W'(pmem_addr), LINE_W'(0));
    @(negedge clk);
    pmem_rdata = DAT_A5; pmem_resp = 1'b1;
    #1;
    check_eq("late_resp_dropped", LINE_W'({icache_resp, dcache_resp}), LINE_W'(0));
    check_eq("late_rdata_dropped", dcache_rdata, '0);
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0;

    check_eq("scoreboard_empty", LINE_W'(exp_q.size()), LINE_W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
